// File: rtl/ula_pkg.sv
// Shared definitions for ula_mc: op codes, FSM states, iterator modes.
// The op-10 encoding is a constant-true flag with a zero result.
package ula_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd6;
    localparam logic [4:0] OP_EQ   = 5'd7;
    localparam logic [4:0] OP_LT   = 5'd8;
    localparam logic [4:0] OP_NE   = 5'd9;
    localparam logic [4:0] OP_TRUE = 5'd10;
    localparam logic [4:0] OP_SLL  = 5'd11;
    localparam logic [4:0] OP_SRL  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;

    // Op 10 drives True high and Resultado to zero.
    localparam logic TRUE_OP_FLAG = 1'b1;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/ula_muldiv_iter.sv
// Iterative unsigned MUL (MSB-first shift-add) and restoring DIV, one bit per cycle.
// Loads on start, runs WIDTH iterations; done/result are valid on the final iteration edge.
module ula_muldiv_iter
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    logic             active_q, active_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   rem_sh;

    // sreg holds the multiplier (MUL) or the dividend turning into the quotient (DIV);
    // acc holds the partial product or the partial remainder.
    always_comb begin
        active_d = active_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        rem_sh   = {acc_q, sreg_q[WIDTH-1]};
        if (start) begin
            active_d = 1'b1;
            mode_d   = mode;
            cnt_d    = CW'(WIDTH - 1);
            sreg_d   = op_a;
            acc_d    = '0;
            opb_d    = op_b;
        end else if (active_q) begin
            if (mode_q == MD_DIV) begin
                if (rem_sh >= {1'b0, opb_q}) begin
                    acc_d  = rem_sh[WIDTH-1:0] - opb_q;
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = rem_sh[WIDTH-1:0];
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d  = {acc_q[WIDTH-2:0], 1'b0} + (sreg_q[WIDTH-1] ? opb_q : '0);
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            active_q <= 1'b0;
            mode_q   <= MD_MUL;
            cnt_q    <= '0;
            sreg_q   <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
        end else begin
            active_q <= active_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            sreg_q   <= sreg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
        end
    end

    assign done        = active_q && (cnt_q == '0);
    assign result      = (mode_q == MD_DIV) ? sreg_d : acc_d;
    assign div_by_zero = (mode_q == MD_DIV) && (opb_q == '0);

endmodule

// File: rtl/ula_mc.sv
// Handshaked multi-cycle ALU; single-cycle ops in 1 cycle, MUL/DIV in WIDTH cycles.
// ULA_MULDIV_EN enables iterative MUL/DIV; without it ops 2/3 are illegal and busy/div_zero are 0.
module ula_mc
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALU_op,
    input  logic             Imm,
    input  logic [WIDTH-1:0] Lido1,
    input  logic [WIDTH-1:0] Lido2,
    input  logic [WIDTH-1:0] estendido,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Resultado,
    output logic             True,
    output logic             div_zero,
    output logic             illegal,
    output logic             busy
);
    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             true_q, true_d;
    logic             illegal_q, illegal_d;
    logic             accept;
    logic [WIDTH-1:0] opb;
`ifdef ULA_MULDIV_EN
    logic             div_zero_q, div_zero_d;
    logic             md_start, md_mode, md_done, md_dz;
    logic [WIDTH-1:0] md_res;

    ula_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clock       (clock),
        .reset       (reset),
        .start       (md_start),
        .mode        (md_mode),
        .op_a        (Lido1),
        .op_b        (Lido2),
        .done        (md_done),
        .result      (md_res),
        .div_by_zero (md_dz)
    );
`endif

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign opb      = Imm ? estendido : Lido2;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        true_d      = true_q;
        illegal_d   = illegal_q;
`ifdef ULA_MULDIV_EN
        div_zero_d  = div_zero_q;
        md_start    = 1'b0;
        md_mode     = MD_MUL;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            res_d       = '0;
            true_d      = 1'b0;
            illegal_d   = 1'b0;
`ifdef ULA_MULDIV_EN
            div_zero_d  = 1'b0;
`endif
            case (ALU_op)
                OP_ADD:  res_d = Lido1 + opb;
                OP_SUB:  res_d = Lido1 - opb;
                OP_AND:  res_d = Lido1 & opb;
                OP_OR:   res_d = Lido1 | opb;
                OP_NOT:  res_d = ~Lido1;
                OP_EQ: begin
                    true_d = (Lido1 == Lido2);
                    res_d  = WIDTH'(true_d);
                end
                OP_LT: begin
                    true_d = (Lido1 < opb);
                    res_d  = WIDTH'(true_d);
                end
                OP_NE: begin
                    true_d = (Lido1 != Lido2);
                    res_d  = WIDTH'(true_d);
                end
                OP_TRUE: true_d = TRUE_OP_FLAG;
                OP_SLL:  res_d = Lido1 << Lido2[SHW-1:0];
                OP_SRL:  res_d = Lido1 >> Lido2[SHW-1:0];
                OP_NOP:  res_d = '0;
`ifdef ULA_MULDIV_EN
                OP_MUL: begin
                    out_valid_d = 1'b0;
                    state_d     = MUL;
                    md_start    = 1'b1;
                    md_mode     = MD_MUL;
                end
                OP_DIV: begin
                    out_valid_d = 1'b0;
                    state_d     = DIV;
                    md_start    = 1'b1;
                    md_mode     = MD_DIV;
                end
`endif
                default: illegal_d = 1'b1;
            endcase
        end
`ifdef ULA_MULDIV_EN
        // Accept needs IDLE, so completion never collides with a new request.
        if ((state_q != IDLE) && md_done) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            res_d       = md_res;
            true_d      = 1'b0;
            illegal_d   = 1'b0;
            div_zero_d  = md_dz;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            true_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ULA_MULDIV_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            true_q      <= true_d;
            illegal_q   <= illegal_d;
`ifdef ULA_MULDIV_EN
            div_zero_q  <= div_zero_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign Resultado = res_q;
    assign True      = true_q;
    assign illegal   = illegal_q;
`ifdef ULA_MULDIV_EN
    assign div_zero  = div_zero_q;
    assign busy      = (state_q != IDLE);
`else
    assign div_zero  = 1'b0;
    assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_ula_mc.sv
// Directed bench for ula_mc (WIDTH=32): vector table for single-cycle ops plus
// hand sequences for MUL/DIV latency, output hold and mid-iteration reset.
module tb_ula_mc;
    import ula_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   ALU_op;
    logic         Imm;
    logic [W-1:0] Lido1, Lido2, estendido;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Resultado;
    logic         True, div_zero, illegal, busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ula_mc #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_op    (ALU_op),
        .Imm       (Imm),
        .Lido1     (Lido1),
        .Lido2     (Lido2),
        .estendido (estendido),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Resultado (Resultado),
        .True      (True),
        .div_zero  (div_zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    typedef struct {
        logic [4:0]   op;
        logic         imm;
        logic [W-1:0] a, b, e;
        logic [W-1:0] res;
        logic         tru;
        logic         ill;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [4:0] op, input logic imm,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] e, input logic [W-1:0] res,
                                input logic tru, input logic ill);
        vec_t v;
        v.op = op; v.imm = imm; v.a = a; v.b = b; v.e = e;
        v.res = res; v.tru = tru; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " out_valid"}, W'(out_valid), 0);
        chk({nm, " Resultado"}, Resultado, 0);
        chk({nm, " True"},      W'(True), 0);
        chk({nm, " div_zero"},  W'(div_zero), 0);
        chk({nm, " illegal"},   W'(illegal), 0);
        chk({nm, " busy"},      W'(busy), 0);
    endtask

    // Accept a MUL/DIV at the next edge and follow it to completion.
    task automatic run_multi(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_res, input logic exp_dz, input string nm);
        int lat;
        bit steady;
        ALU_op = op; Imm = 1'b0; Lido1 = a; Lido2 = b; estendido = '0;
        out_ready = 1'b1; in_valid = 1'b1;
        chk({nm, " in_ready at issue"}, W'(in_ready), 1);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 0;
`ifdef ULA_MULDIV_EN
        steady = 1'b1;
        while (out_valid !== 1'b1 && lat < W + 8) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) steady = 1'b0;
            @(negedge clock);
            lat++;
        end
        chk({nm, " latency"}, W'(lat), W);
        chk({nm, " busy/!in_ready while iterating"}, W'(steady), 1);
        chk({nm, " Resultado"}, Resultado, exp_res);
        chk({nm, " div_zero"}, W'(div_zero), W'(exp_dz));
        chk({nm, " illegal"}, W'(illegal), 0);
        chk({nm, " True"}, W'(True), 0);
        chk({nm, " busy at done"}, W'(busy), 0);
`else
        steady = (exp_res != '0) || exp_dz;
        chk({nm, " out_valid"}, W'(out_valid), 1);
        chk({nm, " latency"}, W'(lat), 0);
        chk({nm, " Resultado"}, Resultado, 0);
        chk({nm, " illegal"}, W'(illegal), 1);
        chk({nm, " div_zero"}, W'(div_zero), 0);
        chk({nm, " busy"}, W'(busy), 0);
        chk({nm, " nonzero expectation"}, W'(steady), 1);
`endif
        @(negedge clock);
    endtask

    initial begin
        int lat;
        bit seen;

        vecs[0]  = mk(OP_ADD,  1'b1, 32'd5,        32'd123,      32'hFFFF_FFFF, 32'd4,         1'b0, 1'b0);
        vecs[1]  = mk(OP_SUB,  1'b0, 32'd10,       32'd3,        32'd0,         32'd7,         1'b0, 1'b0);
        vecs[2]  = mk(OP_SUB,  1'b0, 32'd3,        32'd5,        32'd0,         32'hFFFF_FFFE, 1'b0, 1'b0);
        vecs[3]  = mk(OP_AND,  1'b1, 32'hF0F0,     32'd0,        32'hFF00,      32'hF000,      1'b0, 1'b0);
        vecs[4]  = mk(OP_OR,   1'b0, 32'hF0,       32'h0F,       32'hFFFF_0000, 32'hFF,        1'b0, 1'b0);
        vecs[5]  = mk(OP_NOT,  1'b0, 32'd0,        32'd7,        32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
        vecs[6]  = mk(OP_EQ,   1'b1, 32'd5,        32'd5,        32'd6,         32'd1,         1'b1, 1'b0);
        vecs[7]  = mk(OP_LT,   1'b0, 32'd3,        32'd7,        32'd0,         32'd1,         1'b1, 1'b0);
        vecs[8]  = mk(OP_NE,   1'b0, 32'd9,        32'd9,        32'd0,         32'd0,         1'b0, 1'b0);
        vecs[9]  = mk(OP_LT,   1'b0, 32'd7,        32'd3,        32'd0,         32'd0,         1'b0, 1'b0);
        vecs[10] = mk(OP_LT,   1'b1, 32'd1,        32'd0,        32'h8000_0000, 32'd1,         1'b1, 1'b0);
        vecs[11] = mk(OP_NE,   1'b0, 32'd1,        32'd2,        32'd0,         32'd1,         1'b1, 1'b0);
        vecs[12] = mk(OP_TRUE, 1'b0, 32'd77,       32'd88,       32'd0,         32'd0,         1'b1, 1'b0);
        vecs[13] = mk(OP_SLL,  1'b0, 32'd1,        32'd35,       32'd0,         32'd8,         1'b0, 1'b0);
        vecs[14] = mk(OP_SRL,  1'b0, 32'h8000_0000, 32'd31,      32'd0,         32'd1,         1'b0, 1'b0);
        vecs[15] = mk(OP_NOP,  1'b0, 32'd5,        32'd5,        32'd0,         32'd0,         1'b0, 1'b0);
        vecs[16] = mk(5'd14,   1'b0, 32'd5,        32'd5,        32'd0,         32'd0,         1'b0, 1'b1);
        vecs[17] = mk(5'd31,   1'b0, 32'd5,        32'd5,        32'd0,         32'd0,         1'b0, 1'b1);
        vecs[18] = mk(OP_ADD,  1'b0, 32'hFFFF_FFFF, 32'd2,       32'd9,         32'd1,         1'b0, 1'b0);

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ALU_op = OP_NOP; Imm = 1'b0;
        Lido1 = '0; Lido2 = '0; estendido = '0;

        repeat (2) @(negedge clock);
        chk_idle_outputs("reset");
        reset = 1'b1;
        chk("in_ready after release", W'(in_ready), 1);

        // Back-to-back accepts, output drained every cycle.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            ALU_op = vecs[i].op; Imm = vecs[i].imm;
            Lido1 = vecs[i].a; Lido2 = vecs[i].b; estendido = vecs[i].e;
            in_valid = 1'b1;
            chk($sformatf("vec%0d in_ready", i), W'(in_ready), 1);
            @(negedge clock);
            chk($sformatf("vec%0d out_valid", i), W'(out_valid), 1);
            chk($sformatf("vec%0d Resultado", i), Resultado, vecs[i].res);
            chk($sformatf("vec%0d True", i), W'(True), W'(vecs[i].tru));
            chk($sformatf("vec%0d illegal", i), W'(illegal), W'(vecs[i].ill));
            chk($sformatf("vec%0d div_zero", i), W'(div_zero), 0);
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("drained out_valid", W'(out_valid), 0);

        run_multi(OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, "mul");
        run_multi(OP_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, "div0");
        run_multi(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, "div7");
        run_multi(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, "mul_max");

        // Output hold under backpressure; a competing request must be refused.
        ALU_op = OP_SLL; Imm = 1'b0; Lido1 = 32'd1; Lido2 = 32'd35; out_ready = 1'b0;
        in_valid = 1'b1;
        @(negedge clock);
        ALU_op = OP_ADD; Lido1 = 32'd100; Lido2 = 32'd1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d out_valid", c), W'(out_valid), 1);
            chk($sformatf("hold%0d Resultado", c), Resultado, 32'd8);
            chk($sformatf("hold%0d in_ready", c), W'(in_ready), 0);
            @(negedge clock);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        chk("hold release out_valid", W'(out_valid), 0);
        chk("hold release Resultado", Resultado, 32'd8);

        // Reset at iteration 10 of a DIV must abort it without a result.
        ALU_op = OP_DIV; Lido1 = 32'd100; Lido2 = 32'd7; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_idle_outputs("mid reset");
        reset = 1'b1;
        seen = 1'b0;
        lat = 0;
        while (lat < W + 8) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clock);
            lat++;
        end
        chk("no result after abort", W'(seen), 0);
        chk("in_ready after abort", W'(in_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ula_mc.md
# ula_mc

Multi-cycle, handshaked successor to the processor's combinational ALU, parametrised in datapath width. Decodes the same 5-bit `ALU_op` codes and produces registered `Resultado`/`True`. MULT and DIV run iteratively over `WIDTH` cycles instead of as single-cycle combinational operators. The block sits between operand fetch and writeback/branch logic, using valid/ready handshakes on both sides.

## Interface

- `WIDTH`, default 32, datapath width; must be a power of two, ≥8.
- `SHW`, default $clog2(WIDTH), number of shift-amount bits taken from the LSBs of `Lido2`.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset==0` at a rising edge resets the block.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request this cycle.
- `ALU_op`  in  5  operation code.
- `Imm`  in  1  selects `estendido` instead of `Lido2` as operand B for ADD, SUB, AND, OR and LT.
- `Lido1`, `Lido2`, `estendido`  in  WIDTH each  operands; sampled only on accept.
- `out_valid`  out  1  result held in the output register.
- `out_ready`  in  1  consumer takes the result.
- `Resultado`  out  WIDTH  result.
- `True`  out  1  compare/branch flag.
- `div_zero`  out  1  DIV executed with divisor 0.
- `illegal`  out  1  unsupported op code.
- `busy`  out  1  MUL or DIV iteration in progress.

## Operation

- Accept occurs on `in_valid && in_ready`.
  - `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
  - Back-to-back accepts are allowed when the output register is drained in the same cycle.
- Single-cycle ops write the output register on the accept edge:
  - 0 ADD, 1 SUB, 4 AND, 5 OR: `Lido1` op B.
  - 6 NOT: `~Lido1`.
  - 7 EQ, 8 LT (unsigned, uses B), 9 NE: `Resultado` = 0 or 1, and `True` equals it.
  - 10: `True=1`, `Resultado=0`.
  - 11 SLL, 12 SRL: shift by `Lido2[SHW-1:0]`.
  - 13 NOP: `Resultado=0`, `True=0`.
  - 14–31: `Resultado=0`, `True=0`, `illegal=1`.
- `True` is 0 for every op other than 7/8/9/10. `div_zero` and `illegal` are valid only alongside `out_valid`.
- State machine IDLE → MUL | DIV → IDLE.
  - Accepting op 2 enters MUL; accepting op 3 enters DIV. The iteration counter loads `WIDTH-1`.
  - MUL is unsigned shift-add, one bit per cycle. The result is the low `WIDTH` bits of the product.
  - DIV is unsigned restoring division, one quotient bit per cycle. The result is the quotient; the remainder is discarded.
  - On the iteration with counter==0: write the output register, set `out_valid`, return to IDLE.
- DIV with `Lido2==0`: iterate normally. The result is all ones, and `div_zero=1`.
- MUL/DIV always take the full `WIDTH` iterations; there is no early termination.
- The output register holds its contents stable while `out_valid && !out_ready`.
  - `out_valid` falls on the edge with `out_ready`, unless a new single-cycle op is accepted on that same edge.

## Timing

- Reset values:
  - `out_valid=0`, `Resultado=0`, `True=0`, `div_zero=0`, `illegal=0`, `busy=0`.
  - state=IDLE, counter=0.
  - `in_ready` is 1 in the first cycle after reset is released.
- Single-cycle op accepted at edge k: `out_valid=1` after edge k (latency 1).
- MUL/DIV accepted at edge k:
  - `busy=1` after edge k.
  - Iterations occur on edges k+1 … k+WIDTH.
  - `out_valid=1` and `busy=0` after edge k+WIDTH.
  - `in_ready=0` after edge k, through edge k+WIDTH.
- Reset asserted mid-iteration aborts the operation: no result is produced, and all outputs take their reset values at that edge.
- `in_valid` presented while `busy`: ignored, and the requester must hold it.
- Simultaneous `out_ready` and a new accept: the old result retires and the new one is loaded on the same edge.

## Configuration

- `ULA_MULDIV_EN` defined:
  - MUL/DIV states, the counter and the iterative sub-module are present, as described above.
- `ULA_MULDIV_EN` undefined:
  - Ops 2 and 3 behave as illegal codes: single cycle, `Resultado=0`, `illegal=1`.
  - `busy` is tied to 0 and `div_zero` is tied to 0.
  - The state machine reduces to IDLE.

## Structure

- Package `ula_pkg` holds:
  - op-code localparams (`OP_ADD` … `OP_NOP`, values 0–13);
  - the state enum `{IDLE, MUL, DIV}`;
  - the encoding of the op-10 constant.
- Sub-module `ula_muldiv_iter`, parametrised by `WIDTH`:
  - shared shift register, accumulator and counter for MUL and DIV;
  - `start`/`mode` inputs and a `done` pulse output;
  - instantiated only under `ULA_MULDIV_EN`.

## Test plan

All scenarios use WIDTH=32.

- Reset: hold `reset=0` for 2 cycles → all outputs 0; `in_ready=1` after release.
- ADD, Imm=1, `Lido1=5`, `estendido=0xFFFFFFFF` → `Resultado=4` one cycle after accept, `True=0`.
- LT, Imm=0, `Lido1=3`, `Lido2=7` → `Resultado=1`, `True=1`; then NE with 9/9 issued back-to-back with `out_ready=1` → `Resultado=0`, `True=0` in the next cycle.
- MUL `0x10000 * 0x10001` → `out_valid` exactly 32 cycles after accept; `Resultado=0x00010000`; `in_ready=0` throughout.
- DIV `100 / 0` → `Resultado=0xFFFFFFFF`, `div_zero=1`; DIV `100 / 7` → 14, `div_zero=0`.
- `out_ready=0` for 5 cycles after SLL `1 << 35` → `Resultado=8` held stable, `in_ready=0`. Then assert `reset=0` during a subsequent DIV at iteration 10 → no `out_valid`, all outputs 0.
